fmul_issue_ctrl: RTL

Issue controller for the pipelined FP32 multiplier datapath (mantissa multiply, normalize, round, exponent update). Arbitrates between two requesters, drives operands into the fixed-latency, non-stallable multiplier pipeline, and tracks in-flight operations with a valid/tag shift chain. Results are captured into a small response FIFO. Credit-based issue guarantees no result is ever dropped when the consumer back-pressures.

---
 rtl/fmul_ctrl_pkg.sv | 28 ++
 rtl/fmul_rsp_fifo.sv | 55 +++++
 rtl/fmul_issue_ctrl.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/fmul_ctrl_pkg.sv
// Shared types and defaults for the FP32 multiplier issue controller.
package fmul_ctrl_pkg;

   localparam int unsigned FMUL_W     = 32;
   localparam int unsigned FMUL_LAT   = 5;
   localparam int unsigned FMUL_DEPTH = 4;

   typedef enum logic {
      REQ0 = 1'b0,
      REQ1 = 1'b1
   } req_id_t;

   typedef struct packed {
      logic [FMUL_W-1:0] data;
      logic              id;
      logic              ovf;
      logic              unf;
   } fmul_rsp_t;

   // Pointer width for a power-of-two FIFO depth; never narrower than one bit.
   function automatic int unsigned ptr_w(input int unsigned depth);
      int unsigned w;
      w = 1;
      while ((32'd1 << w) < depth) w++;
      return w;
   endfunction

endpackage

// File: rtl/fmul_rsp_fifo.sv
// Response FIFO for multiplier results; head is zero while empty.
module fmul_rsp_fifo
   import fmul_ctrl_pkg::*;
#(
   parameter  int unsigned DEPTH = FMUL_DEPTH,
   localparam int unsigned PW    = ptr_w(DEPTH),
   localparam int unsigned CW    = PW + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  fmul_rsp_t     push_data,
   input  logic          pop,
   output fmul_rsp_t     head,
   output logic          not_empty,
   output logic [CW-1:0] count
);

   fmul_rsp_t         mem [DEPTH];
   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;
   logic              full;
   logic              do_pop;

   always_comb begin
      not_empty = (count != '0);
      full      = (count == CW'(DEPTH));
      do_pop    = pop & not_empty;
      head      = not_empty ? mem[rd_ptr] : '0;
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_data;
   end

   // Pointers wrap naturally; the extra count bit separates full from empty.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)   wr_ptr <= wr_ptr + PW'(1);
         if (do_pop) rd_ptr <= rd_ptr + PW'(1);
         case ({push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n) !(push && full));

endmodule

// File: rtl/fmul_issue_ctrl.sv
// Issue controller for the pipelined FP32 multiplier: round-robin arbiter, credit counter, valid/id chain.
// Optional sticky exception flags are built only when FMUL_CTRL_FLAGS_EN is defined.
module fmul_issue_ctrl
   import fmul_ctrl_pkg::*;
#(
   parameter int unsigned W     = FMUL_W,
   parameter int unsigned LAT   = FMUL_LAT,
   parameter int unsigned DEPTH = FMUL_DEPTH
) (
   input  logic           CLK,
   input  logic           RST,
   input  logic [1:0]     req_valid,
   output logic [1:0]     req_ready,
   input  logic [2*W-1:0] req_a,
   input  logic [2*W-1:0] req_b,
   output logic           mul_valid,
   output logic [W-1:0]   mul_a,
   output logic [W-1:0]   mul_b,
   input  logic [W-1:0]   mul_res,
   input  logic           mul_ovf,
   input  logic           mul_unf,
   output logic           rsp_valid,
   input  logic           rsp_ready,
   output logic [W-1:0]   rsp_data,
   output logic           rsp_id,
   output logic           rsp_ovf,
   output logic           rsp_unf,
   input  logic           flag_clr,
   output logic           sticky_ovf,
   output logic           sticky_unf
);

   localparam int unsigned PW = ptr_w(DEPTH);
   localparam int unsigned CW = PW + 1;

   req_id_t         ptr;
   req_id_t         other;
   req_id_t         gnt_id;
   logic [1:0]      grant;
   logic            any_grant;
   logic            mul_id;
   logic [LAT-1:0]  v_chain;
   logic [LAT-1:0]  id_chain;
   logic            tail_push;
   logic [CW-1:0]   inflight;
   logic [CW-1:0]   fifo_count;
   logic [CW-1:0]   credit;
   logic            pop;
   fmul_rsp_t       push_data;
   fmul_rsp_t       head;

   // Every slot is reserved at grant time, so the FIFO can absorb all results.
   always_comb begin
      credit = CW'(DEPTH) - inflight - fifo_count;
   end

   always_comb begin
      other  = (ptr == REQ0) ? REQ1 : REQ0;
      grant  = '0;
      gnt_id = ptr;
      if (credit != '0) begin
         if (req_valid[ptr]) begin
            grant[ptr] = 1'b1;
            gnt_id     = ptr;
         end else if (req_valid[other]) begin
            grant[other] = 1'b1;
            gnt_id       = other;
         end
      end
      any_grant = |grant;
      req_ready = grant;
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         ptr       <= REQ0;
         mul_valid <= 1'b0;
         mul_a     <= '0;
         mul_b     <= '0;
         mul_id    <= 1'b0;
      end else begin
         mul_valid <= any_grant;
         if (any_grant) begin
            mul_a  <= (gnt_id == REQ1) ? req_a[2*W-1:W] : req_a[W-1:0];
            mul_b  <= (gnt_id == REQ1) ? req_b[2*W-1:W] : req_b[W-1:0];
            mul_id <= gnt_id;
            ptr    <= (gnt_id == REQ0) ? REQ1 : REQ0;
         end
      end
   end

   // Stage k is valid during the cycle the datapath is k+1 cycles past mul_valid,
   // so the tail lines up with mul_res.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         v_chain  <= '0;
         id_chain <= '0;
      end else begin
         v_chain[0]  <= mul_valid;
         id_chain[0] <= mul_id;
         for (int unsigned i = 1; i < LAT; i++) begin
            v_chain[i]  <= v_chain[i-1];
            id_chain[i] <= id_chain[i-1];
         end
      end
   end

   assign tail_push = v_chain[LAT-1];

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         inflight <= '0;
      end else begin
         case ({any_grant, tail_push})
            2'b10:   inflight <= inflight + CW'(1);
            2'b01:   inflight <= inflight - CW'(1);
            default: inflight <= inflight;
         endcase
      end
   end

   // The response struct carries a package-width data field; W is expected to match it.
   always_comb begin
      push_data      = '0;
      push_data.data = mul_res;
      push_data.id   = id_chain[LAT-1];
      push_data.ovf  = mul_ovf;
      push_data.unf  = mul_unf;
   end

   assign pop = rsp_valid & rsp_ready;

   fmul_rsp_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (CLK),
      .rst_n     (RST),
      .push      (tail_push),
      .push_data (push_data),
      .pop       (pop),
      .head      (head),
      .not_empty (rsp_valid),
      .count     (fifo_count)
   );

   always_comb begin
      rsp_data = head.data;
      rsp_id   = head.id;
      rsp_ovf  = head.ovf;
      rsp_unf  = head.unf;
   end

`ifdef FMUL_CTRL_FLAGS_EN
   // A set in the same cycle as a clear takes priority.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         sticky_ovf <= 1'b0;
         sticky_unf <= 1'b0;
      end else begin
         if (pop && head.ovf)  sticky_ovf <= 1'b1;
         else if (flag_clr)    sticky_ovf <= 1'b0;
         if (pop && head.unf)  sticky_unf <= 1'b1;
         else if (flag_clr)    sticky_unf <= 1'b0;
      end
   end
`else
   logic unused_flag_clr;
   assign unused_flag_clr = flag_clr;
   assign sticky_ovf      = 1'b0;
   assign sticky_unf      = 1'b0;
`endif

endmodule
